// File: rtl/countnox_pkg.sv
// Shared definitions for the countnox scheduler: state encoding, defaults and a
// constant-width helper used to size pointers and the watchdog.
package countnox_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_CNT_W  = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    return res;
  endfunction

endpackage

// File: rtl/countnox_scheduler_rr_arbiter.sv
// Round-robin grant search: first requester above the pointer, wrapping around.
// Purely combinational; the pointer itself lives in the scheduler.
module rr_arbiter
  import countnox_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = (N_REQ > 1) ? clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_rr_ptr,
  output logic [IDX_W-1:0] o_grant_idx,
  output logic             o_grant_valid
);

  logic [IDX_W-1:0] w_cand;

  // Offsets 1..N_REQ so the previous winner is considered last.
  always_comb begin
    o_grant_idx   = '0;
    o_grant_valid = 1'b0;
    w_cand        = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      w_cand = IDX_W'((int'(i_rr_ptr) + i) % N_REQ);
      if (!o_grant_valid && i_req[w_cand]) begin
        o_grant_valid = 1'b1;
        o_grant_idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/countnox_scheduler.sv
// Shares one bit-counting datapath among N_REQ clients: round-robin grant,
// load/go sequencing, wait for done under a watchdog, then respond and ack.
module countnox_scheduler
  import countnox_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = 20
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        ack,
  output logic                    rsp_valid,
  output logic [2:0]              rsp_id,
  output logic [CNT_W-1:0]        rsp_count,
  output logic                    rsp_err,
  output logic                    busy,
  output logic                    dp_load,
  output logic [DATA_W-1:0]       dp_data,
  output logic                    dp_go,
  input  logic                    dp_done,
  input  logic [CNT_W-1:0]        dp_count
);

  localparam int IDX_W = (N_REQ > 1) ? clog2(N_REQ) : 1;
  localparam int WD_W  = clog2(TIMEOUT) + 1;
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] PTR_INIT = IDX_W'(N_REQ - 1);

  state_t             r_state;
  state_t             w_next;
  logic [IDX_W-1:0]   r_sel;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   w_grant_idx;
  logic               w_grant_valid;
  logic [WD_W-1:0]    r_wd;
  logic               w_wd_expired;
  logic [DATA_W-1:0]  r_data;
  logic [DATA_W-1:0]  w_operand;
  logic [2:0]         r_rsp_id;
  logic [CNT_W-1:0]   r_rsp_count;
  logic               r_rsp_err;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .i_req         (req),
    .i_rr_ptr      (r_rr_ptr),
    .o_grant_idx   (w_grant_idx),
    .o_grant_valid (w_grant_valid)
  );

  always_comb begin
    w_operand = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_grant_idx == IDX_W'(k)) w_operand = req_data[k*DATA_W +: DATA_W];
    end
  end

  assign w_wd_expired = (r_wd == WD_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Strobes and ack are decoded from state only, never from req or dp_done.
  always_comb begin
    w_next    = S_IDLE;
    dp_load   = 1'b0;
    dp_go     = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    ack       = '0;
    case (r_state)
      S_IDLE: begin
        busy   = 1'b0;
        w_next = w_grant_valid ? S_LOAD : S_IDLE;
      end
      S_LOAD: begin
        dp_load = 1'b1;
        w_next  = S_START;
      end
      S_START: begin
        dp_go  = 1'b1;
        w_next = S_WAIT;
      end
      S_WAIT: begin
        w_next = (dp_done || w_wd_expired) ? S_RESP : S_WAIT;
      end
      S_RESP: begin
        rsp_valid  = 1'b1;
        ack[r_sel] = 1'b1;
        w_next     = S_IDLE;
      end
      default: begin
        busy   = 1'b0;
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sel       <= '0;
      r_rr_ptr    <= PTR_INIT;
      r_wd        <= '0;
      r_data      <= '0;
      r_rsp_id    <= '0;
      r_rsp_count <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_valid) begin
            r_sel  <= w_grant_idx;
            r_data <= w_operand;
          end
        end
        S_START: r_wd <= '0;
        S_WAIT: begin
          // done wins over an expiring watchdog in the same cycle
          if (dp_done) begin
            r_rsp_id    <= 3'(r_sel);
            r_rsp_count <= dp_count;
            r_rsp_err   <= 1'b0;
          end else if (w_wd_expired) begin
            r_rsp_id    <= 3'(r_sel);
            r_rsp_count <= '0;
            r_rsp_err   <= 1'b1;
          end else if (r_wd != '1) begin
            r_wd <= r_wd + WD_W'(1);
          end
        end
        S_RESP: r_rr_ptr <= r_sel;
        default: ;
      endcase
    end
  end

  assign dp_data   = r_data;
  assign rsp_id    = r_rsp_id;
  assign rsp_count = r_rsp_count;
  assign rsp_err   = r_rsp_err;

endmodule

// File: doc/countnox_scheduler.md
Name: countnox_scheduler

Overview:
- Hardwired FSM controller that shares one bit-counting datapath (load / go / done / count) among N_REQ requesters.
- Arbitrates round-robin and captures the winner's operand.
- Sequences the datapath through load, go and wait-for-done, then returns the count with the requester id.
- A watchdog aborts a run whose done never arrives.
- Sits between client blocks and the counting datapath/control unit pair.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 8, operand width presented to the datapath.
- CNT_W, 4, count width; must hold DATA_W (clog2(DATA_W+1)).
- TIMEOUT, 20, maximum WAIT cycles before abort (2*DATA_W+4).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  N_REQ  per-client request level; held until ack.
- req_data  in  N_REQ*DATA_W  flat operands; client k at bits [k*DATA_W +: DATA_W].
- ack  out  N_REQ  one-hot, one-cycle pulse to the served client.
- rsp_valid  out  1  one-cycle pulse, result valid.
- rsp_id  out  3  index of the served client.
- rsp_count  out  CNT_W  count returned by the datapath; 0 on error.
- rsp_err  out  1  watchdog abort flag, valid with rsp_valid.
- busy  out  1  high whenever state != IDLE.
- dp_load  out  1  one-cycle load strobe to the datapath.
- dp_data  out  DATA_W  captured operand; stable from LOAD through RESP.
- dp_go  out  1  one-cycle start pulse to the datapath.
- dp_done  in  1  datapath completion; sampled only in WAIT.
- dp_count  in  CNT_W  datapath result; sampled when dp_done=1 in WAIT.

Behaviour:
- Clock and reset are fixed: one clock, clk; reset is asynchronous and active-high.
- Reset state: IDLE.
  - All outputs are 0, including ack, dp_data, rsp_* and busy.
  - rr_ptr = N_REQ-1, so client 0 has first priority.
  - Watchdog = 0.
  - Reset mid-operation aborts immediately: no ack and no rsp_valid are issued.
- IDLE:
  - If req != 0, grant the first set bit searching from rr_ptr+1 upward with wrap.
  - Register sel and capture dp_data <= req_data[sel], then go to LOAD.
  - If req == 0, stay in IDLE.
- LOAD: dp_load=1 for one cycle, then go to START.
- START:
  - dp_go=1 for one cycle; clear the watchdog; go to WAIT.
  - dp_done is ignored in START.
- WAIT:
  - If dp_done=1, latch rsp_count <= dp_count, rsp_err <= 0, go to RESP.
  - Else, if watchdog == TIMEOUT-1, set rsp_count <= 0, rsp_err <= 1, go to RESP.
  - Else increment the watchdog.
  - dp_done takes priority over timeout when both occur in the same cycle.
- RESP:
  - rsp_valid=1, rsp_id=sel and ack[sel]=1 for exactly one cycle.
  - rr_ptr <= sel; go to IDLE.
  - rsp_count, rsp_id and rsp_err hold until the next RESP.
- Latency, with grant in cycle t:
  - dp_load in t+1, dp_go in t+2, WAIT from t+3.
  - dp_done seen in cycle d gives rsp_valid and ack in cycle d+1.
  - Minimum grant-to-ack is 4 cycles.
- Back-to-back operation:
  - After RESP, IDLE takes one cycle before the next grant, so grants are at least 5 cycles apart.
  - A client whose req is still high in the cycle after ack is treated as a new request.
- Request withdrawal and stability:
  - req dropped after grant: the transaction still completes and ack is still pulsed.
  - req_data changes after grant: ignored, the captured operand is used.
- Fairness: with all requesters active, service order is 0,1,…,N_REQ-1,0,…
- Arithmetic:
  - The watchdog is clog2(TIMEOUT)+1 bits and saturates; it never wraps.
  - rr_ptr wraps from N_REQ-1 to 0.
- Outputs are registered or decoded from state only; there is no combinational path from req or dp_done to any output.
- Unused state encodings recover to IDLE.

Decomposition:
- Shared package countnox_pkg:
  - state encoding constants S_IDLE, S_LOAD, S_START, S_WAIT, S_RESP (3 bits).
  - clog2 function.
  - DATA_W and CNT_W defaults.
- Sub-module rr_arbiter:
  - Inputs: req and rr_ptr. Outputs: grant index and grant_valid.
  - Purely combinational priority rotation; rr_ptr is owned by the scheduler.

Test Plan:
- Reset then single request: req=4'b0001 with operand 8'hB5; datapath model asserts done 9 cycles after go with count 5.
  - Expect dp_load at t+1 and dp_go at t+2.
  - Expect ack=4'b0001, rsp_id=0, rsp_count=5, rsp_err=0 with rsp_valid high for exactly 1 cycle.
- All four requesters held high continuously: rsp_id sequence 0,1,2,3,0, with grants 5+ cycles apart; each ack is one-hot.
- Timeout: datapath never asserts done.
  - Expect rsp_valid exactly 3+TIMEOUT cycles after grant (23 cycles for TIMEOUT=20) with rsp_err=1 and rsp_count=0.
  - Expect the next request to be served normally.
- Boundary: done asserted in the same cycle the watchdog reaches TIMEOUT-1 with count 7 → rsp_err=0, rsp_count=7.
- Reset mid-WAIT: assert reset for 1 cycle during WAIT.
  - Expect all outputs to go to 0 asynchronously, no ack to be issued, and client 0 to win next when req=4'b1111.
- Data stability and withdrawal: change req_data[1] and drop req[1] after grant.
  - Expect dp_data to keep the original operand and ack[1] to still pulse.
